// File: rtl/cpu_irq_ctrl.sv
// Prioritised external interrupt controller with req/ack/eoi handshake to the exception unit.
// Optional rotating priority is built when IRQ_ROUND_ROBIN_EN is defined.
module cpu_irq_ctrl #(
  parameter int          NUM_IRQ    = 8,
  parameter logic [7:0]  CAUSE_BASE = 8'h80
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               cfg_write,
  input  logic               cfg_read,
  input  logic [2:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               irq_req,
  output logic [7:0]         irq_cause,
  input  logic               irq_ack,
  input  logic               irq_eoi,
  output logic               in_service
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} stateT;

  stateT              state_q;
  logic [NUM_IRQ-1:0] sync1_q, sync2_q, prev_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] enable_q, edge_q;
  logic               ctrl_q;
  logic [3:0]         irqId_q;
  logic               irqReq_q, inService_q;
  logic [7:0]         cause_q;
  logic [31:0]        rdata_q, rdata_d;

  logic [NUM_IRQ-1:0] trigger, clearMask, candidates;
  logic [3:0]         winId;
  logic               unusedWdata;

  assign unusedWdata = ^cfg_wdata[31:NUM_IRQ];

  assign trigger    = sync2_q & (~edge_q | ~prev_q);
  assign candidates = pending_q & enable_q & {NUM_IRQ{ctrl_q}};

  always_comb begin
    clearMask = '0;
    if (cfg_write && cfg_addr == 3'd3)
      clearMask = cfg_wdata[NUM_IRQ-1:0];
    for (int i = 0; i < NUM_IRQ; i++)
      if (state_q == REQ && irq_ack && edge_q[i] && irqId_q == 4'(i))
        clearMask[i] = 1'b1;
    // Set wins over clear, so a level line still asserted stays pending.
    pending_d = (pending_q & ~clearMask) | trigger;
  end

`ifdef IRQ_ROUND_ROBIN_EN
  logic [3:0] lastId_q;
  logic [3:0] hiId;
  logic       hiFound;

  // Lowest candidate above lastId_q wins; otherwise wrap to the lowest overall.
  always_comb begin
    winId   = '0;
    hiId    = '0;
    hiFound = 1'b0;
    for (int i = NUM_IRQ-1; i >= 0; i--) begin
      if (candidates[i]) winId = 4'(i);
      if (candidates[i] && 4'(i) > lastId_q) begin
        hiId    = 4'(i);
        hiFound = 1'b1;
      end
    end
    if (hiFound) winId = hiId;
  end
`else
  always_comb begin
    winId = '0;
    for (int i = NUM_IRQ-1; i >= 0; i--)
      if (candidates[i]) winId = 4'(i);
  end
`endif

  always_comb begin
    rdata_d = rdata_q;
    if (cfg_read) begin
      case (cfg_addr)
        3'd0:    rdata_d = {31'b0, ctrl_q};
        3'd1:    rdata_d = 32'(enable_q);
        3'd2:    rdata_d = 32'(edge_q);
        3'd3:    rdata_d = 32'(pending_q);
        3'd4:    rdata_d = {20'b0, irqId_q, 6'b0, state_q};
        3'd5:    rdata_d = 32'(sync2_q);
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      edge_q    <= '0;
      ctrl_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      sync1_q   <= irq_in;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      pending_q <= pending_d;
      rdata_q   <= rdata_d;
      if (cfg_write) begin
        case (cfg_addr)
          3'd0:    ctrl_q   <= cfg_wdata[0];
          3'd1:    enable_q <= cfg_wdata[NUM_IRQ-1:0];
          3'd2:    edge_q   <= cfg_wdata[NUM_IRQ-1:0];
          default: ;
        endcase
      end
    end
  end

  // Handshake FSM; request and cause stay frozen in REQ whatever the config does.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      irqId_q     <= '0;
      irqReq_q    <= 1'b0;
      cause_q     <= '0;
      inService_q <= 1'b0;
`ifdef IRQ_ROUND_ROBIN_EN
      lastId_q    <= 4'(NUM_IRQ-1);
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (candidates != '0) begin
            state_q  <= REQ;
            irqId_q  <= winId;
            irqReq_q <= 1'b1;
            cause_q  <= CAUSE_BASE + {4'b0, winId};
          end
        end
        REQ: begin
          if (irq_ack) begin
            state_q     <= SERVICE;
            irqReq_q    <= 1'b0;
            inService_q <= 1'b1;
`ifdef IRQ_ROUND_ROBIN_EN
            lastId_q    <= irqId_q;
`endif
          end
        end
        SERVICE: begin
          if (irq_eoi) begin
            state_q     <= IDLE;
            inService_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_rdata  = rdata_q;
  assign irq_req    = irqReq_q;
  assign irq_cause  = cause_q;
  assign in_service = inService_q;

endmodule

// File: tb/tb_cpu_irq_ctrl.sv
// Directed self-checking bench for cpu_irq_ctrl: handshake, triggers, priority, masking, config port, reset.
module tb_cpu_irq_ctrl;

  localparam int NUM_IRQ = 8;

  logic               clock = 1'b0;
  logic               reset_n;
  logic [NUM_IRQ-1:0] irq_in;
  logic               cfg_write, cfg_read;
  logic [2:0]         cfg_addr;
  logic [31:0]        cfg_wdata, cfg_rdata;
  logic               irq_req, irq_ack, irq_eoi, in_service;
  logic [7:0]         irq_cause;

  int compareCount = 0;
  int failCount    = 0;

  cpu_irq_ctrl #(.NUM_IRQ(NUM_IRQ), .CAUSE_BASE(8'h80)) dut (
    .clock(clock), .reset_n(reset_n), .irq_in(irq_in),
    .cfg_write(cfg_write), .cfg_read(cfg_read), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .irq_req(irq_req), .irq_cause(irq_cause), .irq_ack(irq_ack),
    .irq_eoi(irq_eoi), .in_service(in_service)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic cfgWrite(input logic [2:0] a, input logic [31:0] d);
    cfg_write = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_write = 1'b0;
  endtask

  task automatic cfgRead(input logic [2:0] a, output logic [31:0] d);
    cfg_read = 1'b1; cfg_addr = a;
    tick();
    cfg_read = 1'b0;
    d = cfg_rdata;
  endtask

  task automatic pulseAck;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
  endtask

  task automatic pulseEoi;
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
  endtask

  task automatic waitReq(input int maxC, output int cyc);
    cyc = 0;
    while (!irq_req && cyc < maxC) begin
      tick();
      cyc++;
    end
  endtask

  task automatic applyReset;
    reset_n = 1'b0; irq_in = '0; cfg_write = 1'b0; cfg_read = 1'b0;
    cfg_addr = '0; cfg_wdata = '0; irq_ack = 1'b0; irq_eoi = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    logic [31:0] d;
    applyReset();
    compareCount++;
    if ({irq_req, in_service, irq_cause, cfg_rdata} !== 42'd0) begin
      failCount++; $display("[TB] FAIL reset_outputs: got req=%b svc=%b cause=%h rdata=%h required all 0", irq_req, in_service, irq_cause, cfg_rdata);
    end
    cfgRead(3'd4, d);
    compareCount++;
    if (d !== 32'h0) begin failCount++; $display("[TB] FAIL reset_status: got %h required 0", d); end
  endtask

  task automatic test_level;
    int cyc;
    logic [31:0] d;
    applyReset();
    cfgWrite(3'd1, 32'h01);
    cfgWrite(3'd0, 32'h1);
    irq_in = 8'h01;
    waitReq(8, cyc);
    compareCount++;
    if (irq_req !== 1'b1 || cyc > 4) begin failCount++; $display("[TB] FAIL level_latency: got req=%b after %0d cycles required req=1 within 4", irq_req, cyc); end
    compareCount++;
    if (irq_cause !== 8'h80) begin failCount++; $display("[TB] FAIL level_cause: got %h required 80", irq_cause); end
    cfgRead(3'd5, d);
    compareCount++;
    if (d !== 32'h01) begin failCount++; $display("[TB] FAIL level_raw: got %h required 01", d); end
    pulseAck();
    compareCount++;
    if (irq_req !== 1'b0 || in_service !== 1'b1) begin failCount++; $display("[TB] FAIL level_ack: got req=%b svc=%b required req=0 svc=1", irq_req, in_service); end
    tick(3);
    compareCount++;
    if (irq_req !== 1'b0) begin failCount++; $display("[TB] FAIL level_service_block: got req=%b required 0", irq_req); end
    pulseEoi();
    compareCount++;
    if (irq_req !== 1'b0 || in_service !== 1'b0) begin failCount++; $display("[TB] FAIL level_eoi: got req=%b svc=%b required 0 0", irq_req, in_service); end
    tick();
    compareCount++;
    if (irq_req !== 1'b1 || irq_cause !== 8'h80) begin failCount++; $display("[TB] FAIL level_rerequest: got req=%b cause=%h required 1 80", irq_req, irq_cause); end
  endtask

  task automatic test_edge;
    int cyc;
    logic [31:0] d;
    applyReset();
    cfgWrite(3'd2, 32'h04);
    cfgWrite(3'd1, 32'h04);
    cfgWrite(3'd0, 32'h1);
    irq_in = 8'h04; tick(); irq_in = 8'h00;
    waitReq(8, cyc);
    compareCount++;
    if (irq_req !== 1'b1 || irq_cause !== 8'h82) begin failCount++; $display("[TB] FAIL edge_cause: got req=%b cause=%h required 1 82", irq_req, irq_cause); end
    pulseAck();
    cfgRead(3'd3, d);
    compareCount++;
    if (d !== 32'h0) begin failCount++; $display("[TB] FAIL edge_ack_clear: got %h required 0", d); end
    irq_in = 8'h04; tick(); irq_in = 8'h00;
    tick(4);
    cfgRead(3'd3, d);
    compareCount++;
    if (d !== 32'h04 || irq_req !== 1'b0) begin failCount++; $display("[TB] FAIL edge_repend: got pending=%h req=%b required 04 0", d, irq_req); end
    pulseEoi();
    tick();
    compareCount++;
    if (irq_req !== 1'b1 || irq_cause !== 8'h82) begin failCount++; $display("[TB] FAIL edge_reissue: got req=%b cause=%h required 1 82", irq_req, irq_cause); end
  endtask

  task automatic test_simultaneous;
    int cyc;
    applyReset();
    cfgWrite(3'd2, 32'hFF);
    cfgWrite(3'd1, 32'hFF);
    cfgWrite(3'd0, 32'h1);
    irq_in = 8'h28;
    waitReq(8, cyc);
    compareCount++;
    if (irq_req !== 1'b1 || irq_cause !== 8'h83) begin failCount++; $display("[TB] FAIL simul_first: got req=%b cause=%h required 1 83", irq_req, irq_cause); end
    pulseAck();
    pulseEoi();
    waitReq(4, cyc);
    compareCount++;
    if (irq_req !== 1'b1 || irq_cause !== 8'h85) begin failCount++; $display("[TB] FAIL simul_second: got req=%b cause=%h required 1 85", irq_req, irq_cause); end
  endtask

  task automatic test_priority;
    int cyc;
    logic [7:0] expSecond;
`ifdef IRQ_ROUND_ROBIN_EN
    expSecond = 8'h86;
`else
    expSecond = 8'h81;
`endif
    applyReset();
    cfgWrite(3'd1, 32'hFF);
    cfgWrite(3'd0, 32'h1);
    irq_in = 8'h42;
    waitReq(8, cyc);
    compareCount++;
    if (irq_req !== 1'b1 || irq_cause !== 8'h81) begin failCount++; $display("[TB] FAIL prio_first: got req=%b cause=%h required 1 81", irq_req, irq_cause); end
    pulseAck();
    pulseEoi();
    waitReq(4, cyc);
    compareCount++;
    if (irq_req !== 1'b1 || irq_cause !== expSecond) begin failCount++; $display("[TB] FAIL prio_second: got req=%b cause=%h required 1 %h", irq_req, irq_cause, expSecond); end
  endtask

  task automatic test_mask_w1c;
    logic [31:0] d;
    applyReset();
    cfgWrite(3'd0, 32'h1);
    irq_in = 8'h10; tick(4); irq_in = 8'h00; tick(3);
    cfgRead(3'd3, d);
    compareCount++;
    if (d !== 32'h10 || irq_req !== 1'b0) begin failCount++; $display("[TB] FAIL mask_pending: got pending=%h req=%b required 10 0", d, irq_req); end
    cfgWrite(3'd3, 32'h10);
    cfgRead(3'd3, d);
    compareCount++;
    if (d !== 32'h0) begin failCount++; $display("[TB] FAIL mask_w1c: got %h required 0", d); end
    cfgWrite(3'd1, 32'h10);
    tick(3);
    compareCount++;
    if (irq_req !== 1'b0) begin failCount++; $display("[TB] FAIL mask_no_req: got %b required 0", irq_req); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic [31:0] d;
    applyReset();
    cfgWrite(3'd1, 32'h02);
    cfgWrite(3'd0, 32'h1);
    irq_in = 8'h02;
    waitReq(8, cyc);
    cfgWrite(3'd1, 32'h00);
    cfgWrite(3'd0, 32'h0);
    tick(3);
    compareCount++;
    if (irq_req !== 1'b1 || irq_cause !== 8'h81) begin failCount++; $display("[TB] FAIL hold_req: got req=%b cause=%h required 1 81", irq_req, irq_cause); end
    cfgRead(3'd4, d);
    compareCount++;
    if (d !== 32'h101) begin failCount++; $display("[TB] FAIL hold_status: got %h required 101", d); end
    irq_ack = 1'b1; irq_eoi = 1'b1; tick(); irq_ack = 1'b0; irq_eoi = 1'b0;
    tick(2);
    compareCount++;
    if (in_service !== 1'b1 || irq_req !== 1'b0) begin failCount++; $display("[TB] FAIL ack_eoi_same: got svc=%b req=%b required 1 0", in_service, irq_req); end
    cfgRead(3'd4, d);
    compareCount++;
    if (d !== 32'h102) begin failCount++; $display("[TB] FAIL service_status: got %h required 102", d); end
  endtask

  task automatic test_cfg_port;
    logic [31:0] d;
    applyReset();
    cfgWrite(3'd1, 32'h5A);
    cfg_write = 1'b1; cfg_read = 1'b1; cfg_addr = 3'd1; cfg_wdata = 32'h33;
    tick();
    cfg_write = 1'b0; cfg_read = 1'b0;
    compareCount++;
    if (cfg_rdata !== 32'h5A) begin failCount++; $display("[TB] FAIL cfg_prewrite: got %h required 5a", cfg_rdata); end
    cfgRead(3'd1, d);
    compareCount++;
    if (d !== 32'h33) begin failCount++; $display("[TB] FAIL cfg_postwrite: got %h required 33", d); end
    cfgWrite(3'd2, 32'hFFFF_FFFF);
    cfgRead(3'd2, d);
    compareCount++;
    if (d !== 32'hFF) begin failCount++; $display("[TB] FAIL cfg_upper_zero: got %h required ff", d); end
    cfgWrite(3'd2, 32'h0);
    tick(2);
    compareCount++;
    if (cfg_rdata !== 32'hFF) begin failCount++; $display("[TB] FAIL cfg_hold: got %h required ff", cfg_rdata); end
    cfgWrite(3'd6, 32'hFFFF_FFFF);
    cfgRead(3'd6, d);
    compareCount++;
    if (d !== 32'h0) begin failCount++; $display("[TB] FAIL cfg_addr6: got %h required 0", d); end
  endtask

  task automatic test_async_reset;
    int cyc;
    logic [31:0] d;
    applyReset();
    cfgWrite(3'd2, 32'h0F);
    cfgWrite(3'd1, 32'h01);
    cfgWrite(3'd0, 32'h1);
    irq_in = 8'h01;
    waitReq(8, cyc);
    pulseAck();
    cfgRead(3'd4, d);
    #2;
    reset_n = 1'b0;
    #1;
    compareCount++;
    if ({irq_req, in_service, irq_cause, cfg_rdata} !== 42'd0) begin
      failCount++; $display("[TB] FAIL async_reset_outputs: got req=%b svc=%b cause=%h rdata=%h required all 0", irq_req, in_service, irq_cause, cfg_rdata);
    end
    irq_in = '0;
    tick();
    reset_n = 1'b1;
    tick();
    for (int a = 0; a < 6; a++) begin
      cfgRead(3'(a), d);
      compareCount++;
      if (d !== 32'h0) begin failCount++; $display("[TB] FAIL async_reset_reg%0d: got %h required 0", a, d); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    test_reset();
    test_level();
    test_edge();
    test_simultaneous();
    test_priority();
    test_mask_w1c();
    test_back_to_back();
    test_cfg_port();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/cpu_irq_ctrl.md
Name: cpu_irq_ctrl

Overview:
Prioritised external interrupt controller feeding the CPU exception unit's interrupt entry path.
- Synchronises NUM_IRQ asynchronous lines and latches them as level or edge events.
- Selects one winner and presents it as a single request/cause pair with a req/ack handshake.
- Blocks further requests until the CPU signals end-of-interrupt (RTI retire).
- Configured through a small register port driven from the CSR write/read path.

Parameters:
NUM_IRQ, 8, number of external interrupt lines (1..16)
CAUSE_BASE, 8'h80, cause code of line 0; line i reports CAUSE_BASE+i

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
irq_in  in  NUM_IRQ  raw external interrupt lines, asynchronous
cfg_write  in  1  register write strobe
cfg_read  in  1  register read strobe
cfg_addr  in  3  register index
cfg_wdata  in  32  write data
cfg_rdata  out  32  read data, valid 1 cycle after cfg_read
irq_req  out  1  interrupt request to exception unit
irq_cause  out  8  cause code of the presented interrupt, stable while irq_req=1
irq_ack  in  1  single-cycle pulse: exception unit has taken the interrupt
irq_eoi  in  1  single-cycle pulse: RTI retired at P4
in_service  out  1  high from ack to eoi

Behaviour:
- Reset (async assert, sync deassert by the system): all registers 0, state IDLE, irq_req=0, irq_cause=0, cfg_rdata=0, in_service=0. Reset mid-handshake abandons the interrupt; nothing is retained.
- Synchroniser: 2 flops per line (sync2), plus prev = sync2 delayed 1 cycle. Line-to-pending latency is 3 cycles.
- Trigger: EDGE[i]=1 means rising edge (sync2 & ~prev). EDGE[i]=0 means level (sync2 high).
- pending[i] sets on trigger regardless of ENABLE.
- pending[i] clears on a W1C write to PENDING, or on ack of line i when EDGE[i]=1.
- Set and clear in the same cycle: set wins. A level line that is still high therefore cannot be cleared.
- candidates = pending & ENABLE, gated by CTRL[0] (global enable).
- State IDLE: if candidates != 0, latch winner id and go to REQ. irq_req=1 and irq_cause=CAUSE_BASE+id from the next cycle.
- State REQ: irq_req and irq_cause are held stable.
  - The request is never retracted, even if the source is disabled or cleared.
  - On irq_ack, go to SERVICE. irq_req drops the following cycle. in_service=1.
- State SERVICE: new candidates are ignored. On irq_eoi, go to IDLE and drop in_service. A new request can be raised no earlier than 1 cycle after eoi.
- Ignored: irq_ack in IDLE or SERVICE; irq_eoi in IDLE or REQ.
- ack and eoi in the same cycle in REQ: ack is processed, eoi is ignored.
- Default arbitration: fixed priority, lowest index wins.
- Register map, by cfg_addr:
  - 0 CTRL: [0] global enable.
  - 1 ENABLE: [NUM_IRQ-1:0].
  - 2 EDGE: [NUM_IRQ-1:0].
  - 3 PENDING: read = pending; write-1-to-clear.
  - 4 STATUS (RO): [1:0] state (0 IDLE, 1 REQ, 2 SERVICE), [11:8] current id.
  - 5 RAW (RO): sync2.
  - 6, 7: read 0, writes ignored.
- Unused upper bits read 0.
- cfg_rdata is registered. It holds its value when cfg_read=0.
- A write and read to the same address in the same cycle returns the pre-write value.
- A CTRL[0]=0 write in REQ does not cancel the pending handshake.

Optional Feature:
IRQ_ROUND_ROBIN_EN:
- Defined: rotating priority. A last_id register is updated on each ack, and search starts at last_id+1, wrapping modulo NUM_IRQ. last_id resets to NUM_IRQ-1, so line 0 has first priority after reset.
- Undefined: fixed lowest-index priority, and no last_id register is built.

Test Plan:
1. Single level IRQ: ENABLE=0x01, CTRL=1, irq_in[0]=1 -> irq_req=1 with irq_cause=0x80 within 4 cycles. Ack -> in_service=1, irq_req=0 next cycle. Eoi while line still high -> re-request 0x80 after 1 cycle.
2. Edge vs level clear: EDGE=0x04, ENABLE=0x04, pulse irq_in[2] for 1 cycle -> cause 0x82. Ack -> PENDING reads 0. Second pulse during SERVICE -> PENDING=0x04, request reissued after eoi.
3. Simultaneous lines: ENABLE=0xFF, irq_in=0x28 at once -> fixed mode grants 0x83 then, after eoi, 0x85. Round-robin mode with last_id=3 -> 0x85 first.
4. Masking and W1C: pending 0x10 with ENABLE=0 -> no irq_req. Write PENDING=0x10 -> reads 0. Then set ENABLE=0x10 -> still no request.
5. Request hold: in REQ with cause 0x81, write ENABLE=0 and CTRL=0 -> irq_req stays 1 and cause stays 0x81 until ack.
6. Async reset: assert reset_n=0 in SERVICE -> same cycle irq_req=0, in_service=0, STATUS=0, all registers 0.
